// File: rtl/alu_mul_seq_if.sv
// Bundle between the execute stage / ALU and the alu_mul_seq sequencer.
//   master : requester side (drives start/op_a/op_b) plus the ALU's data_out
//   slave  : the sequencer (drives busy/done/result/zero and the ALU request)
// Signals:
//   start, op_a, op_b        request and signed operands
//   busy, done, result, zero sequencer status and registered product
//   alu_operation, alu_in1, alu_in2  opcode/operands presented to the ALU
//   alu_data_out             ALU combinational result, same cycle
interface alu_mul_seq_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  start;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic [ADDR_WIDTH-1:0] alu_operation;
    logic [DATA_WIDTH-1:0] alu_in1;
    logic [DATA_WIDTH-1:0] alu_in2;
    logic [DATA_WIDTH-1:0] alu_data_out;

    modport master (
        output start, op_a, op_b, alu_data_out,
        input  busy, done, result, zero, alu_operation, alu_in1, alu_in2
    );

    modport slave (
        input  start, op_a, op_b, alu_data_out,
        output busy, done, result, zero, alu_operation, alu_in1, alu_in2
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier sequencer that drives the shared combinational ALU.
// Owns the accumulator, multiplicand and multiplier registers and produces
// (op_a*op_b) mod 2**DATA_WIDTH with a one-cycle done pulse.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   alu_mul_seq_if.slave: start/op_a/op_b in, busy/done/result/zero out,
//         alu_operation/alu_in1/alu_in2 out, alu_data_out in
// Optional feature: define MUL_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero (result unchanged, latency shorter).
// OP_* parameters must be set to the ADDr/SL/NOP encodings of the ALU.
module alu_mul_seq #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ADDR_WIDTH = 5,
    parameter int unsigned           CNTR_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] OP_NOP     = 5'd0,
    parameter logic [ADDR_WIDTH-1:0] OP_ADDR    = 5'd1,
    parameter logic [ADDR_WIDTH-1:0] OP_SL      = 5'd2
) (
    input  logic          clk,
    input  logic          rst,
    alu_mul_seq_if.slave  bus
);

    localparam logic [CNTR_WIDTH-1:0] CNT_LAST = CNTR_WIDTH'(DATA_WIDTH - 1);

    // The zero-cycle TEST decision is folded into LOAD and SHIFT.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic [ADDR_WIDTH-1:0] alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] alu_in1_q, alu_in1_d;
    logic [DATA_WIDTH-1:0] alu_in2_q, alu_in2_d;

    logic [DATA_WIDTH-1:0] mplier_shr;

    // State register and datapath/output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            alu_op_q  <= OP_NOP;
            alu_in1_q <= '0;
            alu_in2_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            alu_op_q  <= alu_op_d;
            alu_in1_q <= alu_in1_d;
            alu_in2_q <= alu_in2_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        mplier_shr = mplier_q >> 1;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                acc_d    = '0;
                mcand_d  = bus.op_a;
                mplier_d = bus.op_b;
                cnt_d    = '0;
                state_d  = bus.op_b[0] ? S_ADD : S_SHIFT;
`ifdef MUL_EARLY_EXIT_EN
                if (bus.op_b == '0) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_ADD: begin
                acc_d   = bus.alu_data_out;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                mcand_d  = bus.alu_data_out;
                mplier_d = mplier_shr;
                cnt_d    = cnt_q + CNTR_WIDTH'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
`ifdef MUL_EARLY_EXIT_EN
                end else if (mplier_shr == '0) begin
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = mplier_shr[0] ? S_ADD : S_SHIFT;
                end
            end
            S_DONE: begin
                // start seen here is dropped; requester must re-assert in IDLE
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they register cleanly
    // and line up with the state they belong to.
    always_comb begin
        alu_op_d  = OP_NOP;
        alu_in1_d = acc_d;
        alu_in2_d = '0;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        result_d  = result_q;
        zero_d    = zero_q;

        case (state_d)
            S_ADD: begin
                alu_op_d  = OP_ADDR;
                alu_in1_d = acc_d;
                alu_in2_d = mcand_d;
            end
            S_SHIFT: begin
                alu_op_d  = OP_SL;
                alu_in1_d = mcand_d;
                alu_in2_d = '0;
            end
            S_DONE: begin
                result_d = acc_d;
                zero_d   = (acc_d == '0);
            end
            default: begin
            end
        endcase
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.result        = result_q;
    assign bus.zero          = zero_q;
    assign bus.alu_operation = alu_op_q;
    assign bus.alu_in1       = alu_in1_q;
    assign bus.alu_in2       = alu_in2_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed cases plus random operands
// against an arithmetic reference (product, popcount-based latency, ADD count).
// Latency is counted in clock edges from the cycle start is raised, the
// sampling edge included.
module tb_alu_mul_seq;

    localparam int unsigned     DW      = 8;
    localparam int unsigned     AW      = 5;
    localparam logic [AW-1:0]   OP_NOP  = 5'd0;
    localparam logic [AW-1:0]   OP_ADDR = 5'd1;
    localparam logic [AW-1:0]   OP_SL   = 5'd2;

    logic clk = 1'b0;
    logic rst;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] prev_res;
    logic          prev_zero;

    alu_mul_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    alu_mul_seq #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CNTR_WIDTH (4),
        .OP_NOP     (OP_NOP),
        .OP_ADDR    (OP_ADDR),
        .OP_SL      (OP_SL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Combinational ALU model.
    always_comb begin
        case (bus_if.alu_operation)
            OP_ADDR: bus_if.alu_data_out = DW'(bus_if.alu_in1 + bus_if.alu_in2);
            OP_SL:   bus_if.alu_data_out = DW'({bus_if.alu_in1, 1'b0});
            default: bus_if.alu_data_out = bus_if.alu_in1;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] ref_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int unsigned p;
        p = 32'(a) * 32'(b);
        return DW'(p % (1 << DW));
    endfunction

    function automatic int ref_lat(input logic [DW-1:0] b);
        int pc;
        int hi;
        pc = $countones(b);
        hi = -1;
        for (int i = 0; i < int'(DW); i++) if (b[i]) hi = i;
`ifdef MUL_EARLY_EXIT_EN
        if (b == '0) return 2;
        return 2 + hi + 1 + pc;
`else
        return 2 + int'(DW) + pc;
`endif
    endfunction

    // One multiply; optionally re-pulses start mid-op or during the DONE cycle.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int inject_at, input bit start_in_done);
        int n;
        int adds;
        int bad;
        bit seen;
        logic [DW-1:0] exp;
        exp  = ref_prod(a, b);
        n    = 0;
        adds = 0;
        seen = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op_a  = a;
        bus_if.op_b  = b;
        while (n < 100 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) bus_if.start = 1'b0;
            if (inject_at != 0 && n == inject_at) begin
                bus_if.start = 1'b1;
                bus_if.op_a  = 8'd9;
                bus_if.op_b  = 8'd9;
            end
            if (inject_at != 0 && n == inject_at + 1) bus_if.start = 1'b0;
            if (bus_if.alu_operation == OP_ADDR) adds++;
            if (n == 3) check_eq("result_held", 32'(bus_if.result), 32'(prev_res));
            if (bus_if.done) seen = 1'b1;
        end
        bus_if.start = 1'b0;
        if (!seen) begin
            check_eq("done_timeout", 32'(seen), 32'd1);
        end else begin
            check_eq("latency", 32'(n), 32'(ref_lat(b)));
            check_eq("result", 32'(bus_if.result), 32'(exp));
            check_eq("zero", 32'(bus_if.zero), 32'(exp == '0));
            check_eq("add_count", 32'(adds), 32'($countones(b)));
            check_eq("busy_at_done", 32'(bus_if.busy), 32'd1);
            if (start_in_done) bus_if.start = 1'b1;
            @(posedge clk);
            #1;
            bus_if.start = 1'b0;
            check_eq("busy_after_done", 32'(bus_if.busy), 32'd0);
            check_eq("done_pulse_len", 32'(bus_if.done), 32'd0);
            bad = 0;
            repeat (inject_at != 0 ? 20 : 4) begin
                @(posedge clk);
                #1;
                if (bus_if.busy || bus_if.done) bad++;
            end
            check_eq("idle_quiet", 32'(bad), 32'd0);
            prev_res  = exp;
            prev_zero = (exp == '0);
        end
    endtask

    initial begin
        int dones;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;

        rst          = 1'b1;
        bus_if.start = 1'b0;
        bus_if.op_a  = '0;
        bus_if.op_b  = '0;
        prev_res     = '0;
        prev_zero    = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(bus_if.busy), 32'd0);
        check_eq("rst_done", 32'(bus_if.done), 32'd0);
        check_eq("rst_result", 32'(bus_if.result), 32'd0);
        check_eq("rst_zero", 32'(bus_if.zero), 32'd1);
        check_eq("rst_alu_op", 32'(bus_if.alu_operation), 32'(OP_NOP));
        @(negedge clk);
        rst = 1'b0;

        run_op(8'd6, 8'd7, 0, 1'b0);
        run_op(8'hFD, 8'd5, 0, 1'b0);
        run_op(8'd16, 8'd16, 0, 1'b0);
        run_op(8'h55, 8'd0, 0, 1'b0);
        run_op(8'h7B, 8'hFF, 0, 1'b0);
        run_op(8'd3, 8'd3, 4, 1'b0);
        run_op(8'd11, 8'd13, 0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            ra = DW'($urandom);
            rb = DW'($urandom);
            run_op(ra, rb, 0, 1'b0);
        end

        // Reset in the middle of an operation.
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op_a  = 8'd6;
        bus_if.op_b  = 8'd7;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(bus_if.busy), 32'd0);
        check_eq("midrst_done", 32'(bus_if.done), 32'd0);
        check_eq("midrst_result", 32'(bus_if.result), 32'd0);
        check_eq("midrst_zero", 32'(bus_if.zero), 32'd1);
        dones = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus_if.done) dones++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus_if.done || bus_if.busy) dones++;
        end
        check_eq("midrst_no_done", 32'(dones), 32'd0);
        prev_res  = '0;
        prev_zero = 1'b1;
        run_op(8'd2, 8'd2, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle sequencer that computes a product by driving the existing combinational ALU through a shift-add loop.
- Owns the accumulator, multiplicand and multiplier registers.
- Presents `ADDr`, `SL` and `NOP` opcodes (values from instructions.v) to the ALU and captures its data_out each cycle.
- Sits between the core's execute stage and the ALU; the execute stage issues start and waits for done.

Parameters:
- DATA_WIDTH, 8, operand/result width; matches ALU DATA_WIDTH.
- ADDR_WIDTH, 5, ALU opcode width; matches ALU operation port.
- CNTR_WIDTH, 4, iteration counter width; must satisfy 2**CNTR_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op_a  input  DATA_WIDTH  multiplicand, signed two's complement.
- op_b  input  DATA_WIDTH  multiplier, signed two's complement.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result valid.
- result  output  DATA_WIDTH  (op_a*op_b) mod 2**DATA_WIDTH, registered.
- zero  output  1  registered, result==0.
- alu_operation  output  ADDR_WIDTH  opcode driven to ALU.
- alu_in1  output  DATA_WIDTH  ALU in1_acc.
- alu_in2  output  DATA_WIDTH  ALU in2_reg.
- alu_data_out  input  DATA_WIDTH  ALU data_out, combinational same cycle.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, result=0, zero=1, acc=0, mcand=0, mplier=0, cnt=0.
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD: acc<=0, mcand<=op_a, mplier<=op_b, cnt<=0 -> TEST.
    - op_a/op_b are sampled at the LOAD edge, i.e. the cycle after start. The requester holds them stable for that cycle.
  - TEST (0 cycles, combinational decision): mplier[0]=1 -> ADD, else -> SHIFT.
  - ADD: alu_operation=`ADDr, alu_in1=acc, alu_in2=mcand; acc<=alu_data_out -> SHIFT.
  - SHIFT: alu_operation=`SL, alu_in1=mcand; mcand<=alu_data_out.
    - Internally mplier<=mplier>>1 (logical) and cnt<=cnt+1.
    - If cnt==DATA_WIDTH-1 -> DONE, else TEST.
  - DONE: result<=acc, zero<=(acc==0), done=1 for exactly this cycle -> IDLE.
- Cycle-level outputs:
  - In IDLE, LOAD and DONE: alu_operation=`NOP, alu_in1=acc, alu_in2=0.
  - In ADD/SHIFT, unused ALU input is 0.
  - Only the ALU's low DATA_WIDTH bits are used; overflow discarded (wrap-around). Signed and unsigned operands give the same low bits.
- Latency: done asserted 2+DATA_WIDTH+popcount(op_b) cycles after the edge on which start is sampled.
- Boundary and simultaneous-event rules:
  - start while busy: ignored, no queueing.
  - start in the DONE cycle: ignored; it must be reasserted in IDLE.
  - Back-to-back throughput: one op per latency+1 cycles.
  - result/zero hold their value from DONE until the next DONE; they are not cleared at start.
  - op_b=0: always SHIFT, never ADD.
  - op_b=all ones: ADD every iteration.
  - Reset mid-operation: abort immediately, outputs to reset values, no done pulse.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined:
  - LOAD goes directly to DONE when op_b==0.
  - SHIFT goes to DONE when the shifted mplier==0 (no remaining set bits), in addition to the cnt limit.
  - Latency = 2 + (index of highest set bit of op_b + 1) + popcount(op_b); op_b=0 gives 2.
- Undefined: fixed DATA_WIDTH iterations; latency per Behaviour.
- result is identical in both builds.

Test Plan (DATA_WIDTH=8):
- op_a=6, op_b=7, start pulse -> result=42, zero=0, done pulse after 13 cycles (8 with MUL_EARLY_EXIT_EN).
- op_a=0xFD (-3), op_b=5 -> result=0xF1 (-15), done after 12 cycles (7 with EN).
- op_a=16, op_b=16 -> result=0x00 (256 wraps), zero=1, done after 11 cycles (8 with EN).
- op_a=0x55, op_b=0 -> result=0, zero=1, no `ADDr ever on alu_operation, done after 10 cycles (2 with EN).
- Start op_a=3, op_b=3; reassert start with op_a=9, op_b=9 while busy -> single done, result=9; busy low exactly one cycle after done.
- Start op_a=6, op_b=7; assert rst 4 cycles later -> busy=0, done never pulses, result=0, zero=1; fresh start 2*2 -> result=4.
